// File: rtl/approx_mult_err_sweeper_if.sv
// Operand/product bus between the error sweeper and the 4x4 approximate
// multiplier under test.
interface approx_mult_err_sweeper_if;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] approx_p;

  modport master (output op_a, output op_b, input approx_p);
  modport slave  (input op_a, input op_b, output approx_p);
endinterface

// File: rtl/approx_mult_err_sweeper.sv
// Exhaustive error characterisation of a 4x4 approximate multiplier: drives
// all 256 operand pairs and accumulates error statistics against a*b.
module approx_mult_err_sweeper #(
  parameter int PIPE_LAT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  approx_mult_err_sweeper_if.master  mul,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                sum_abs_err,
  output logic [16:0]                sum_sgn_err,
  output logic [7:0]                 max_abs_err,
  output logic [8:0]                 err_count,
  output logic [3:0]                 worst_a,
  output logic [3:0]                 worst_b
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [1:0] DRAIN_LAST = 2'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  state_t     state;
  logic [7:0] cnt;
  logic       issue_v;
  logic [1:0] drain_cnt;

  // The operand registers are the pair counter itself, so they hold 15/15
  // once the sweep has issued its last pair.
  assign mul.op_a = cnt[7:4];
  assign mul.op_b = cnt[3:0];

  // Sample point: {valid, a, b} delayed to line up with approx_p.
  logic       s_v;
  logic [3:0] s_a;
  logic [3:0] s_b;

  generate
    if (PIPE_LAT == 0) begin : g_comb
      assign s_v = issue_v;
      assign s_a = cnt[7:4];
      assign s_b = cnt[3:0];
    end else begin : g_pipe
      logic [PIPE_LAT-1:0]      dl_v;
      logic [PIPE_LAT-1:0][3:0] dl_a;
      logic [PIPE_LAT-1:0][3:0] dl_b;

      // NOTE: the delay line is reset, not just the valid bit, so an aborted
      // sweep can never leak a stale pair into the next one.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dl_v <= '0;
          dl_a <= '0;
          dl_b <= '0;
        end else begin
          dl_v[0] <= issue_v;
          dl_a[0] <= cnt[7:4];
          dl_b[0] <= cnt[3:0];
          for (int i = 1; i < PIPE_LAT; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_a[i] <= dl_a[i-1];
            dl_b[i] <= dl_b[i-1];
          end
        end
      end

      assign s_v = dl_v[PIPE_LAT-1];
      assign s_a = dl_a[PIPE_LAT-1];
      assign s_b = dl_b[PIPE_LAT-1];
    end
  endgenerate

  logic [7:0]        exact;
  logic signed [8:0] diff;
  logic [7:0]        abs_err;

  assign exact   = {4'd0, s_a} * {4'd0, s_b};
  assign diff    = $signed({1'b0, mul.approx_p}) - $signed({1'b0, exact});
  assign abs_err = diff[8] ? 8'(-diff) : diff[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      issue_v     <= 1'b0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum_abs_err <= '0;
      sum_sgn_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the
      // pre-edge values and later assignments (the IDLE clear) take priority.
      done <= 1'b0;

      if (s_v) begin
        sum_abs_err <= sum_abs_err + {8'd0, abs_err};
        sum_sgn_err <= sum_sgn_err + {{8{diff[8]}}, diff};
        if (diff != 9'sd0) err_count <= err_count + 9'd1;
        // Strict compare keeps the earliest pair on ties.
        if (abs_err > max_abs_err) begin
          max_abs_err <= abs_err;
          worst_a     <= s_a;
          worst_b     <= s_b;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= SWEEP;
            busy        <= 1'b1;
            cnt         <= '0;
            issue_v     <= 1'b1;
            sum_abs_err <= '0;
            sum_sgn_err <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
          end
        end
        SWEEP: begin
          if (cnt == 8'd255) begin
            issue_v <= 1'b0;
            if (PIPE_LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LAST;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_err_sweeper.sv
// Bench for approx_mult_err_sweeper: a combinational-stub instance and a
// two-stage-stub instance checked against an arithmetic reference model.
module tb_approx_mult_err_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start2;
  logic [1:0] mode;
  logic [7:0] rnd_tab [256];

  int total  = 0;
  int passed = 0;

  approx_mult_err_sweeper_if if0 ();
  approx_mult_err_sweeper_if if2 ();

  logic        busy0, done0, busy2, done2;
  logic [15:0] sa0, sa2;
  logic [16:0] ss0, ss2;
  logic [7:0]  mx0, mx2;
  logic [8:0]  ec0, ec2;
  logic [3:0]  wa0, wb0, wa2, wb2;

  approx_mult_err_sweeper #(.PIPE_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mul(if0.master),
    .busy(busy0), .done(done0), .sum_abs_err(sa0), .sum_sgn_err(ss0),
    .max_abs_err(mx0), .err_count(ec0), .worst_a(wa0), .worst_b(wb0));

  approx_mult_err_sweeper #(.PIPE_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mul(if2.master),
    .busy(busy2), .done(done2), .sum_abs_err(sa2), .sum_sgn_err(ss2),
    .max_abs_err(mx2), .err_count(ec2), .worst_a(wa2), .worst_b(wb2));

  // Multiplier stubs: 0 exact, 1 LSB masked, 2 constant 0xFF, 3 random table.
  function automatic logic [7:0] stub_f(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ex;
    ex = {4'd0, a} * {4'd0, b};
    case (m)
      2'd0:    return ex;
      2'd1:    return ex & 8'hFE;
      2'd2:    return 8'hFF;
      default: return rnd_tab[{a, b}];
    endcase
  endfunction

  always_comb if0.approx_p = stub_f(mode, if0.op_a, if0.op_b);

  logic [7:0] stage1, stage2;
  always @(posedge clk) begin
    stage1 <= stub_f(mode, if2.op_a, if2.op_b);
    stage2 <= stage1;
  end
  assign if2.approx_p = stage2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      logic [7:0]  ex;
      r  = $urandom;
      ex = 8'((i >> 4) * (i & 15));
      case (r[1:0])
        2'd0: rnd_tab[i] = ex;
        2'd1: rnd_tab[i] = ex + {5'd0, r[4:2]};
        2'd2: rnd_tab[i] = ex - {5'd0, r[4:2]};
        default: rnd_tab[i] = r[15:8];
      endcase
    end
  endtask

  // Reference statistics over all 256 pairs in A-major order.
  int e_sa, e_ss, e_mx, e_ec, e_wa, e_wb;
  task automatic model();
    e_sa = 0; e_ss = 0; e_mx = 0; e_ec = 0; e_wa = 0; e_wb = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        int d, ad;
        d  = int'(stub_f(mode, 4'(a), 4'(b))) - a * b;
        ad = (d < 0) ? -d : d;
        e_sa += ad;
        e_ss += d;
        if (d != 0) e_ec++;
        if (ad > e_mx) begin e_mx = ad; e_wa = a; e_wb = b; end
      end
  endtask

  task automatic check_stats(input int lat, input string tag);
    logic [15:0] sa; logic [16:0] ss; logic [7:0] mx; logic [8:0] ec;
    logic [3:0] wa, wb;
    sa = lat ? sa2 : sa0; ss = lat ? ss2 : ss0; mx = lat ? mx2 : mx0;
    ec = lat ? ec2 : ec0; wa = lat ? wa2 : wa0; wb = lat ? wb2 : wb0;
    model();
    check({tag, ".sum_abs"}, 32'(sa), 32'(e_sa));
    check({tag, ".sum_sgn"}, 32'($signed(ss)), 32'(e_ss));
    check({tag, ".max_abs"}, 32'(mx), 32'(e_mx));
    check({tag, ".err_cnt"}, 32'(ec), 32'(e_ec));
    check({tag, ".worst_a"}, 32'(wa), 32'(e_wa));
    check({tag, ".worst_b"}, 32'(wb), 32'(e_wb));
  endtask

  // Bounded run: start pulse, optional extra start pokes, 300 observed cycles.
  int busy_cyc, done_cnt, done_at;
  task automatic sweep(input int lat, input logic [1:0] m, input int poke_cyc, input bit poke_done);
    mode = m; busy_cyc = 0; done_cnt = 0; done_at = -1;
    if (lat != 0) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      logic bz, dn;
      bz = lat ? busy2 : busy0;
      dn = lat ? done2 : done0;
      if (bz) busy_cyc++;
      if (dn) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        if (poke_done) begin if (lat != 0) start2 = 1'b1; else start0 = 1'b1; end
      end
      if (c == poke_cyc) begin if (lat != 0) start2 = 1'b1; else start0 = 1'b1; end
      @(posedge clk); #1;
      start0 = 1'b0; start2 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; mode = 2'd0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy0", 32'(busy0), 32'd0);
    check("rst.done0", 32'(done0), 32'd0);
    check("rst.ops0", 32'({if0.op_a, if0.op_b}), 32'd0);
    check("rst.sum_abs0", 32'(sa0), 32'd0);
    check("rst.err_cnt2", 32'(ec2), 32'd0);
    check("rst.busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact multiplier, combinational.
    sweep(0, 2'd0, 0, 1'b0);
    check("exact0.busy_cyc", 32'(busy_cyc), 32'd256);
    check("exact0.done_cnt", 32'(done_cnt), 32'd1);
    check("exact0.done_at", 32'(done_at), 32'd257);
    check("exact0.ops_hold", 32'({if0.op_a, if0.op_b}), 32'hFF);
    check_stats(0, "exact0");

    // LSB-masked multiplier.
    sweep(0, 2'd1, 0, 1'b0);
    check_stats(0, "mask0");
    check("mask0.err_const", 32'(ec0), 32'd64);

    // Constant 0xFF multiplier.
    sweep(0, 2'd2, 0, 1'b0);
    check_stats(0, "ff0");
    check("ff0.sum_abs_const", 32'(sa0), 32'd50880);

    // Random-error multiplier, two independent tables.
    for (int k = 0; k < 2; k++) begin
      fill_random();
      sweep(0, 2'd3, 0, 1'b0);
      check_stats(0, "rnd0");
    end

    // Two-stage pipelined stub.
    sweep(2, 2'd0, 0, 1'b0);
    check("exact2.busy_cyc", 32'(busy_cyc), 32'd258);
    check("exact2.done_at", 32'(done_at), 32'd259);
    check("exact2.done_cnt", 32'(done_cnt), 32'd1);
    check_stats(2, "exact2");
    sweep(2, 2'd1, 0, 1'b0);
    check_stats(2, "mask2");
    fill_random();
    sweep(2, 2'd3, 0, 1'b0);
    check_stats(2, "rnd2");

    // Reset during SWEEP cycle 100 discards the sweep.
    mode = 2'd3;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (99) begin @(posedge clk); #1; end
    check("abort.busy_before", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort.busy", 32'(busy0), 32'd0);
    check("abort.done", 32'(done0), 32'd0);
    check("abort.ops", 32'({if0.op_a, if0.op_b}), 32'd0);
    check("abort.sum_abs", 32'(sa0), 32'd0);
    check("abort.sum_sgn", 32'(ss0), 32'd0);
    check("abort.max_abs", 32'(mx0), 32'd0);
    check("abort.err_cnt", 32'(ec0), 32'd0);
    check("abort.worst", 32'({wa0, wb0}), 32'd0);
    begin
      int late_done = 0;
      for (int c = 0; c < 300; c++) begin
        if (done0) late_done++;
        @(posedge clk); #1;
      end
      check("abort.no_done", 32'(late_done), 32'd0);
    end
    sweep(0, 2'd3, 0, 1'b0);
    check("after_abort.busy_cyc", 32'(busy_cyc), 32'd256);
    check_stats(0, "after_abort");

    // Start pokes during SWEEP and DONE are ignored.
    sweep(0, 2'd3, 50, 1'b1);
    check("poke.busy_cyc", 32'(busy_cyc), 32'd256);
    check("poke.done_cnt", 32'(done_cnt), 32'd1);
    check_stats(0, "poke");
    sweep(2, 2'd1, 50, 1'b1);
    check("poke2.busy_cyc", 32'(busy_cyc), 32'd258);
    check("poke2.done_cnt", 32'(done_cnt), 32'd1);
    check_stats(2, "poke2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
